// File: rtl/protocolo_scheduler_if.sv
// protocolo_scheduler_if
//   Bundles the requester-side and engine-side signals of protocolo_scheduler.
//
//   Parameters
//     N_REQ    number of requesters (2..8)
//
//   Signals
//     req      [N_REQ]  per-requester pending request (level)
//     op       [N_REQ]  per-requester command select (0 = command A, 1 = command B)
//     grant    [N_REQ]  one-hot ownership of the protocol engine
//     done     [1]      one-cycle completion pulse
//     err      [1]      one-cycle error pulse, only together with done
//     done_id  [IDW]    index of the finishing requester, valid with done
//     busy     [1]      scheduler is not idle
//     eng_e    [2]      drive to the protocol engine E input
//     eng_y    [2]      protocol engine Y response
//
//   Modports
//     slave    the scheduler itself
//     master   the surrounding environment (requesters plus engine)
interface protocolo_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic             err;
  logic [IDW-1:0]   done_id;
  logic             busy;
  logic [1:0]       eng_e;
  logic [1:0]       eng_y;

  modport slave (
    input  req, op, eng_y,
    output grant, done, err, done_id, busy, eng_e
  );

  modport master (
    output req, op, eng_y,
    input  grant, done, err, done_id, busy, eng_e
  );
endinterface

// File: rtl/protocolo_scheduler.sv
// protocolo_scheduler
//   Round-robin scheduler sharing one 2-bit handshake protocol engine among
//   N_REQ requesters. The winner's command is pushed through the engine with
//   a START / ARM / CHECK sequence, the engine response Y is checked at every
//   step, and completion (with error flag) is reported to the winner.
//
//   Optional feature: define PROTO_SCHED_RETRY_EN to allow one RECOVER-and-
//   retry per transaction after a response mismatch. Without it the first
//   mismatch finishes the transaction with err=1.
//
//   Ports
//     clk        rising-edge clock, shared with the protocol engine
//     reset      asynchronous, active-high
//     bus        protocolo_scheduler_if.slave (req/op/grant/done/err/done_id/
//                busy/eng_e/eng_y)
//     dbg_state  current FSM state encoding, for observation only
//
//   Handshake: a requester raises req (level) and keeps op stable until its
//   grant bit rises; req/op are sampled only in IDLE. The winner owns the
//   engine while grant is set. The transaction ends with a single-cycle done
//   (err qualifies it, done_id names the winner). A requester that still
//   holds req afterwards simply competes again under round-robin order.
module protocolo_scheduler #(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  protocolo_scheduler_if.slave   bus,
  output logic [2:0]             dbg_state
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_ARM     = 3'd2,
    ST_CHECK   = 3'd3,
`ifdef PROTO_SCHED_RETRY_EN
    ST_RECOVER = 3'd4,
`endif
    ST_FIN     = 3'd5
  } state_t;

  state_t         state;
  logic [IDW-1:0] cur_id;
  logic           cur_op;
  logic [IDW-1:0] last_id;
  logic           done_q;
  logic           err_q;
  logic [IDW-1:0] done_id_q;
`ifdef PROTO_SCHED_RETRY_EN
  logic           retry_used;
`endif

  logic           match_arm;
  logic           match_chk;
  logic           step_bad;
  logic           owns;
  logic [IDW-1:0] winner;

  // Round-robin pick: the first set bit at offsets 1..N_REQ from last.
  // Iterating from the far end lets the nearest offset overwrite the result.
  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] last,
                                             input logic [N_REQ-1:0] r);
    logic [IDW-1:0] idx;
    rr_next = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % N_REQ);
      if (r[idx]) rr_next = idx;
    end
  endfunction

  assign winner    = rr_next(last_id, bus.req);
  // eng_y is the engine's Mealy output and is checked in the same cycle.
  assign match_arm = (bus.eng_y == 2'b01);
  assign match_chk = (bus.eng_y == {1'b1, cur_op});
  assign step_bad  = ((state == ST_ARM) && !match_arm) ||
                     ((state == ST_CHECK) && !match_chk);

  always_comb begin
    owns = (state == ST_START) || (state == ST_ARM) || (state == ST_CHECK);
`ifdef PROTO_SCHED_RETRY_EN
    if (state == ST_RECOVER) owns = 1'b1;
`endif
  end

  // E drive. In ARM the command is only issued on a good response; otherwise
  // E=00 sends the engine back to S0 so the next transaction starts clean.
  always_comb begin
    bus.eng_e = 2'b00;
    case (state)
      ST_START: bus.eng_e = 2'b01;
      ST_ARM:   bus.eng_e = match_arm ? {1'b1, cur_op} : 2'b00;
      default:  bus.eng_e = 2'b00;
    endcase
  end

  assign bus.grant   = owns ? (N_REQ'(1) << cur_id) : '0;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.done_id = done_id_q;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_id     <= '0;
      cur_op     <= 1'b0;
      last_id    <= IDW'(N_REQ - 1);
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      done_id_q  <= '0;
`ifdef PROTO_SCHED_RETRY_EN
      retry_used <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef PROTO_SCHED_RETRY_EN
          retry_used <= 1'b0;
`endif
          if (|bus.req) begin
            cur_id  <= winner;
            cur_op  <= bus.op[winner];
            last_id <= winner;
            state   <= ST_START;
          end
        end
        ST_START: state <= ST_ARM;
        ST_ARM, ST_CHECK: begin
          if (step_bad) begin
`ifdef PROTO_SCHED_RETRY_EN
            if (!retry_used) begin
              retry_used <= 1'b1;
              state      <= ST_RECOVER;
            end else begin
              state     <= ST_FIN;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              done_id_q <= cur_id;
            end
`else
            state     <= ST_FIN;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            done_id_q <= cur_id;
`endif
          end else if (state == ST_ARM) begin
            state <= ST_CHECK;
          end else begin
            state     <= ST_FIN;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            done_id_q <= cur_id;
          end
        end
`ifdef PROTO_SCHED_RETRY_EN
        ST_RECOVER: state <= ST_START;
`endif
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
